// File: rtl/mod503_pkg.sv
// Shared constants, state encoding and modular helpers for the mod-503 channel.
// Widths are sized so that MOD < 2^RES_W and 2^IDX_W >= NCHUNK.
package mod503_pkg;

    localparam int MOD     = 503;
    localparam int RES_W   = 9;
    localparam int CHUNK_W = 6;
    localparam int OP_W    = 18;
    localparam int NCHUNK  = (OP_W + CHUNK_W - 1) / CHUNK_W;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Modular add of two in-range residues; the carry bit catches 502+502.
    function automatic logic [RES_W-1:0] mod_add(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b);
        logic [RES_W:0] s;
        logic [RES_W:0] d;
        s = {1'b0, a} + {1'b0, b};
        d = s - (RES_W + 1)'(MOD);
        if (s >= (RES_W + 1)'(MOD)) begin
            mod_add = d[RES_W-1:0];
        end else begin
            mod_add = s[RES_W-1:0];
        end
    endfunction

    // Single conditional subtraction folding a raw RES_W value into [0, MOD).
    function automatic logic [RES_W-1:0] mod_fold(input logic [RES_W-1:0] x);
        if (x >= RES_W'(MOD)) begin
            mod_fold = x - RES_W'(MOD);
        end else begin
            mod_fold = x;
        end
    endfunction

endpackage

// File: rtl/mod503_add.sv
// Combinational mod-MOD adder; shared with the channel datapath.
module mod503_add
    import mod503_pkg::*;
(
    input  logic [RES_W-1:0] a_i,
    input  logic [RES_W-1:0] b_i,
    output logic [RES_W-1:0] sum_o
);

    assign sum_o = mod_add(a_i, b_i);

endmodule

// File: rtl/mod503_cmul_seq.sv
// Sequences an operand through per-chunk constant-multiply LUTs, accumulating mod MOD.
// Optional LUT range checking and lut_err port: define MOD503_LUT_RANGE_CHK_EN.
module mod503_cmul_seq
    import mod503_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_operand,
    output logic [IDX_W-1:0]   lut_idx,
    output logic [CHUNK_W-1:0] lut_addr,
    input  logic [RES_W-1:0]   lut_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RES_W-1:0]   out_residue,
    output logic               busy
`ifdef MOD503_LUT_RANGE_CHK_EN
    ,
    output logic               lut_err
`endif
);

    localparam int PAD_W = NCHUNK * CHUNK_W;

    state_t             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [PAD_W-1:0]   op_pad_s;
    logic [CHUNK_W-1:0] chunk_s;
    logic [RES_W-1:0]   term_s;
    logic [RES_W-1:0]   sum_s;
    logic               last_s;
    logic               accept_s;

    assign op_pad_s = PAD_W'(op_q);
    assign last_s   = (idx_q == IDX_W'(NCHUNK - 1));
    assign accept_s = (state_q == IDLE) && in_valid;

    // Chunk selected by the index register; bits beyond OP_W read as zero.
    always_comb begin
        chunk_s = {CHUNK_W{1'b0}};
        for (int k = 0; k < NCHUNK; k++) begin
            chunk_s = (idx_q == IDX_W'(k)) ? op_pad_s[k*CHUNK_W +: CHUNK_W] : chunk_s;
        end
    end

`ifdef MOD503_LUT_RANGE_CHK_EN
    logic err_q, err_d;
    logic lut_oor_s;

    assign lut_oor_s = (lut_data >= RES_W'(MOD));
    assign term_s    = mod_fold(lut_data);

    // Sticky range flag: cleared by a new accept, set by any bad RUN lookup.
    always_comb begin
        err_d = err_q;
        if (accept_s) begin
            err_d = 1'b0;
        end else if ((state_q == RUN) && lut_oor_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Range flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign lut_err = err_q;
`else
    assign term_s = lut_data;
`endif

    mod503_add u_add (
        .a_i   (acc_q),
        .b_i   (term_s),
        .sum_o (sum_s)
    );

    // Controller next-state, datapath updates and LUT port drive.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        lut_idx  = {IDX_W{1'b0}};
        lut_addr = {CHUNK_W{1'b0}};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_operand;
                    acc_d   = {RES_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                lut_idx  = idx_q;
                lut_addr = chunk_s;
                acc_d    = sum_s;
                if (last_s) begin
                    idx_d   = {IDX_W{1'b0}};
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, accumulator and index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= {OP_W{1'b0}};
            acc_q   <= {RES_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    // Handshake flags decode straight from the state register so reset is immediate.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign out_residue = acc_q;

endmodule

// File: tb/tb_mod503_cmul_seq.sv
// Self-checking bench for mod503_cmul_seq against a plain-arithmetic (x*81) mod 503 model.
module tb_mod503_cmul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_operand;
    logic [1:0]  lut_idx;
    logic [5:0]  lut_addr;
    logic [8:0]  lut_data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_residue;
    logic        busy;
`ifdef MOD503_LUT_RANGE_CHK_EN
    logic        lut_err;
`endif

    int errors = 0;
    int checks = 0;

    logic        ovr_en = 1'b0;
    logic [8:0]  ovr_val = 9'd0;

    always #5 clk = ~clk;

    mod503_cmul_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_operand  (in_operand),
        .lut_idx     (lut_idx),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_residue (out_residue),
        .busy        (busy)
`ifdef MOD503_LUT_RANGE_CHK_EN
        ,
        .lut_err     (lut_err)
`endif
    );

    function automatic int lut_model(input int k, input int a);
        longint p;
        p = longint'(1) << (6 * k);
        return int'((longint'(a) * 81 * p) % 503);
    endfunction

    function automatic int golden(input int x);
        return int'((longint'(x) * 81) % 503);
    endfunction

    always_comb begin
        lut_data = ovr_en ? ovr_val : 9'(lut_model(int'(lut_idx), int'(lut_addr)));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 12) begin
            step();
            cyc++;
        end
    endtask

    task automatic pulse_ready();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run_op(input int x);
        int cyc;
        int exp;
        exp = golden(x);
        in_operand = 18'(x);
        in_valid   = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            step();
            cyc++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        step();
        in_valid   = 1'b0;
        in_operand = 18'($urandom);
        chk("busy_run", 32'(busy), 32'd1);
        chk("in_ready_run", 32'(in_ready), 32'd0);
        chk("lut_idx_first", 32'(lut_idx), 32'd0);
        chk("lut_addr_first", 32'(lut_addr), 32'(x & 63));
        wait_out(cyc);
        chk("latency", 32'(cyc), 32'd3);
        chk("residue", 32'(out_residue), 32'(exp));
        chk("lut_idx_done", 32'(lut_idx), 32'd0);
        chk("lut_addr_done", 32'(lut_addr), 32'd0);
        pulse_ready();
        chk("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        int a;
        int b;
        int exp;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_operand = 18'd0;
        out_ready  = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_residue", 32'(out_residue), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lut_idx", 32'(lut_idx), 32'd0);
        chk("rst_lut_addr", 32'(lut_addr), 32'd0);
`ifdef MOD503_LUT_RANGE_CHK_EN
        chk("rst_lut_err", 32'(lut_err), 32'd0);
`endif
        rst = 1'b0;
        step();

        // Directed operands.
        run_op(1);
        run_op(64);
        run_op(0);
        run_op(262143);

        // Source holds in_valid; consumer stalls five cycles.
        a = 1000;
        b = 777;
        in_operand = 18'(a);
        in_valid   = 1'b1;
        step();
        in_operand = 18'(b);
        chk("b2b_in_ready_run", 32'(in_ready), 32'd0);
        wait_out(cyc);
        chk("b2b_latency", 32'(cyc), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_residue", 32'(out_residue), 32'(golden(a)));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready_at_ready", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
        chk("b2b_in_ready_after", 32'(in_ready), 32'd1);
        chk("b2b_out_valid_after", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk("b2b_second_busy", 32'(busy), 32'd1);
        wait_out(cyc);
        chk("b2b_second_residue", 32'(out_residue), 32'(golden(b)));
        pulse_ready();

        // Inject 502 twice then 0: accumulator goes 502 then 501.
        exp = ((502 + 502) % 503 + 0) % 503;
        ovr_en     = 1'b1;
        ovr_val    = 9'd502;
        in_operand = 18'd0;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        ovr_val = 9'd0;
        wait_out(cyc);
        chk("inject_502", 32'(out_residue), 32'(exp));
        ovr_en = 1'b0;
        pulse_ready();

        // Randomised sweep.
        for (int i = 0; i < 20; i++) begin
            run_op(int'($urandom_range(0, 262143)));
        end

        // Asynchronous reset in the second RUN cycle.
        in_operand = 18'd12345;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_lut_idx", 32'(lut_idx), 32'd0);
        chk("arst_residue", 32'(out_residue), 32'd0);
        #3;
        rst = 1'b0;
        step();
        chk("arst_stays_idle", 32'(busy), 32'd0);
        run_op(5);
        chk("op5_ref", 32'(golden(5)), 32'(out_residue));

`ifdef MOD503_LUT_RANGE_CHK_EN
        // Out-of-range LUT word: flagged, contributes 510-503.
        ovr_en     = 1'b1;
        ovr_val    = 9'd510;
        in_operand = 18'd0;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        ovr_val = 9'd0;
        wait_out(cyc);
        chk("range_err_set", 32'(lut_err), 32'd1);
        chk("range_term", 32'(out_residue), 32'((510 - 503) % 503));
        ovr_en = 1'b0;
        pulse_ready();
        chk("range_err_sticky", 32'(lut_err), 32'd1);
        in_operand = 18'd1;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        chk("range_err_clear", 32'(lut_err), 32'd0);
        wait_out(cyc);
        chk("range_next_residue", 32'(out_residue), 32'(golden(1)));
        pulse_ready();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
